// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : MEM-to-WB bundle and register-file write / forwarding port
//                for the writeback stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_stage_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   parameter int LANE_W  = $clog2(DATA_W / 8)
);
   // MEM stage -> WB stage
   logic                      m_valid;
   logic                      m_wreg;
   logic [REG_AW-1:0]         m_rd;
   logic [SEL_W-1:0]          m_sel;
   logic [NUM_SRC*DATA_W-1:0] m_src;
   logic [1:0]                m_ld_size;
   logic                      m_ld_uns;
   logic [LANE_W-1:0]         m_addr_lo;
   logic                      wb_stall;
   logic                      wb_flush;
   // WB stage -> register file / forwarding bus / status
   logic                      rf_we;
   logic [REG_AW-1:0]         rf_wa;
   logic [DATA_W-1:0]         rf_wd;
   logic                      w_valid;
   logic                      err;
   logic [31:0]               retired;

   modport master (
      output m_valid, m_wreg, m_rd, m_sel, m_src, m_ld_size, m_ld_uns,
             m_addr_lo, wb_stall, wb_flush,
      input  rf_we, rf_wa, rf_wd, w_valid, err, retired
   );

   modport slave (
      input  m_valid, m_wreg, m_rd, m_sel, m_src, m_ld_size, m_ld_uns,
             m_addr_lo, wb_stall, wb_flush,
      output rf_we, rf_wa, rf_wd, w_valid, err, retired
   );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register, N-source writeback select, load
//                lane extraction with sign/zero extension, single-fire
//                register-file write, sticky error flag and retire counter.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   parameter int LANE_W  = $clog2(DATA_W / 8)
) (
   input  wire logic clk,
   input  wire logic rst_n,
   wb_stage_if.slave bus
);

   localparam logic [SEL_W-1:0] c_SEL_LOAD = SEL_W'(1);

   // WB pipeline register
   logic                r_valid;
   logic                r_wreg;
   logic [REG_AW-1:0]   r_rd;
   logic [SEL_W-1:0]    r_sel;
   logic                r_bad;
   logic [DATA_W-1:0]   r_word;
   logic [1:0]          r_ld_size;
   logic                r_ld_uns;
   logic [LANE_W-1:0]   r_addr_lo;
   logic                r_fired;
   logic                r_err;
   logic [31:0]         r_retired;

   logic [31:0]         w_sel_ext;
   logic                w_sel_bad;
   logic [DATA_W-1:0]   w_src_word;
   logic                w_first;
   logic                w_is_load;
   logic                w_misal;
   logic [DATA_W-1:0]   w_shift_b;
   logic [DATA_W-1:0]   w_shift_h;
   logic [DATA_W-1:0]   w_wd;

   assign w_sel_ext = 32'(bus.m_sel);
   assign w_sel_bad = (w_sel_ext >= 32'(NUM_SRC));

   // Pick the addressed source word; an out-of-range index yields zero
   always_comb begin
      w_src_word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_sel_ext == 32'(i)) begin
            w_src_word = bus.m_src[i*DATA_W +: DATA_W];
         end
      end
   end

   // A resident instruction gets exactly one "first" cycle; stall afterwards only holds it
   assign w_first   = r_valid & ~r_fired;
   assign w_is_load = (r_sel == c_SEL_LOAD);
   assign w_misal   = w_is_load &
                      (((r_ld_size == 2'b01) & r_addr_lo[0]) |
                       (r_ld_size[1] & (r_addr_lo != '0)));

   assign w_shift_b = r_word >> {r_addr_lo, 3'b000};
   assign w_shift_h = r_word >> {r_addr_lo[LANE_W-1:1], 4'b0000};

   // Load lane extraction; non-load sources pass straight through
   always_comb begin
      w_wd = r_word;
      if (w_is_load) begin
         case (r_ld_size)
            2'b00:   w_wd = {{(DATA_W-8){w_shift_b[7] & ~r_ld_uns}}, w_shift_b[7:0]};
            2'b01:   w_wd = {{(DATA_W-16){w_shift_h[15] & ~r_ld_uns}}, w_shift_h[15:0]};
            default: w_wd = r_word;
         endcase
      end
   end

   // WB register: reset > flush > stall (hold, mark fired) > capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_wreg    <= 1'b0;
         r_rd      <= '0;
         r_sel     <= '0;
         r_bad     <= 1'b0;
         r_word    <= '0;
         r_ld_size <= 2'b00;
         r_ld_uns  <= 1'b0;
         r_addr_lo <= '0;
         r_fired   <= 1'b0;
      end else if (bus.wb_flush) begin
         r_valid   <= 1'b0;
         r_fired   <= 1'b0;
      end else if (bus.wb_stall) begin
         r_fired   <= r_fired | r_valid;
      end else begin
         r_valid   <= bus.m_valid;
         r_wreg    <= bus.m_wreg;
         r_rd      <= bus.m_rd;
         r_sel     <= bus.m_sel;
         r_bad     <= w_sel_bad;
         r_word    <= w_src_word;
         r_ld_size <= bus.m_ld_size;
         r_ld_uns  <= bus.m_ld_uns;
         r_addr_lo <= bus.m_addr_lo;
         r_fired   <= 1'b0;
      end
   end

   // Sticky error: bad source index or misaligned load seen when the instruction fires
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_first & (r_bad | w_misal)) begin
         r_err <= 1'b1;
      end
   end

   // Retire counter advances once per resident instruction, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_first) begin
         r_retired <= r_retired + 32'd1;
      end
   end

   assign bus.rf_we   = w_first & r_wreg & (r_rd != '0) & ~w_misal;
   assign bus.rf_wa   = r_rd;
   assign bus.rf_wd   = w_wd;
   assign bus.w_valid = r_valid;
   assign bus.err     = r_err;
   assign bus.retired = r_retired;

endmodule
`default_nettype wire
